// File: rtl/sensor_poll_pkg.sv
// Shared types and constants for the sensor poll scheduler: FSM encoding,
// PIO data-register address and debounce agreement threshold.
package sensor_poll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_ADDR      = 2'd0;
    localparam int         DEBOUNCE_THRESHOLD = 3;

endpackage

// File: rtl/poll_tick_gen.sv
// Poll tick generator: counts 0..POLL_DIV-1 while enabled and pulses o_tick
// for one cycle on the wrap; the count is held at zero while disabled.
module poll_tick_gen #(
    parameter int POLL_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == CNT_W'(POLL_DIV - 1));
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (!i_enable || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Avalon-MM read master that sweeps N single-bit PIO sensors on every poll tick
// and raises a level IRQ on change. Define SENSOR_POLL_DEBOUNCE_EN for 3-sweep debounce.
module sensor_poll_scheduler
    import sensor_poll_pkg::*;
#(
    parameter int N_SENSORS = 4,
    parameter int POLL_DIV  = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    output logic [N_SENSORS-1:0] o_avm_sel,
    output logic                 o_avm_read,
    output logic [1:0]           o_avm_address,
    input  logic [31:0]          i_avm_readdata,
    output logic [N_SENSORS-1:0] o_sensor_state,
    output logic [N_SENSORS-1:0] o_changed,
    input  logic [N_SENSORS-1:0] i_irq_ack,
    output logic                 o_irq,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

    poll_state_t          r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [N_SENSORS-1:0] r_sensorState;
    logic [N_SENSORS-1:0] r_changed;
    logic                 r_irq;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_sample;
    logic                 w_accept;
    logic                 w_lastIdx;
    logic [N_SENSORS-1:0] w_oneHot;
    logic [N_SENSORS-1:0] w_set;
    logic                 w_unusedRdata;

    poll_tick_gen #(.POLL_DIV(POLL_DIV)) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .o_tick   (w_tick)
    );

    assign w_sample      = i_avm_readdata[0];
    assign w_unusedRdata = ^i_avm_readdata[31:1];
    assign w_oneHot      = N_SENSORS'(1) << r_idx;
    assign w_lastIdx     = (r_idx == IDX_W'(N_SENSORS - 1));
    assign w_set         = w_accept ? w_oneHot : '0;

`ifdef SENSOR_POLL_DEBOUNCE_EN
    logic [N_SENSORS-1:0] r_cand;
    logic [1:0]           r_agree [N_SENSORS];
    logic [1:0]           w_agreeNext;

    // A differing sample extends the run only if it matches the stored candidate.
    always_comb begin
        w_agreeNext = 2'd0;
        if (w_sample != r_sensorState[r_idx]) begin
            if (r_cand[r_idx] == w_sample && r_agree[r_idx] != 2'd0) begin
                w_agreeNext = r_agree[r_idx] + 2'd1;
            end else begin
                w_agreeNext = 2'd1;
            end
        end
        w_accept = (r_state == ST_CAPTURE) && (w_agreeNext == 2'(DEBOUNCE_THRESHOLD));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cand <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                r_agree[i] <= 2'd0;
            end
        end else if (r_state == ST_CAPTURE) begin
            r_cand[r_idx]  <= w_sample;
            r_agree[r_idx] <= w_accept ? 2'd0 : w_agreeNext;
        end
    end
`else
    assign w_accept = (r_state == ST_CAPTURE) && (w_sample != r_sensorState[r_idx]);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && i_enable) begin
                        r_idx   <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_lastIdx) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_tick && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // A new change beats a same-cycle acknowledge so no edge is ever lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sensorState <= '0;
            r_changed     <= '0;
            r_irq         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sensorState[r_idx] <= w_sample;
            end
            r_changed <= (r_changed & ~i_irq_ack) | w_set;
            r_irq     <= |r_changed;
        end
    end

    assign o_avm_read     = (r_state == ST_ISSUE);
    assign o_avm_sel      = o_avm_read ? w_oneHot : '0;
    assign o_avm_address  = PIO_DATA_ADDR;
    assign o_sensor_state = r_sensorState;
    assign o_changed      = r_changed;
    assign o_irq          = r_irq;
    assign o_overrun      = r_overrun;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed self-checking bench for sensor_poll_scheduler: one instance with a
// 20-cycle poll period for sweep/IRQ/reset behaviour, one with 8 cycles for overrun.
module tb_sensor_poll_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetA, enableA, readA, irqA, overrunA, busyA;
    logic [3:0]  selA, stateA, changedA, ackA, slaveValsA, prevSelA;
    logic [1:0]  addrA;
    logic [31:0] readdataA;

    logic        resetB, enableB, readB, irqB, overrunB, busyB;
    logic [3:0]  selB, stateB, changedB;
    logic [1:0]  addrB;

    int assertCount = 0;
    int failCount   = 0;

    sensor_poll_scheduler #(.N_SENSORS(4), .POLL_DIV(20)) dutA (
        .i_clk(clk), .i_reset(resetA), .i_enable(enableA),
        .o_avm_sel(selA), .o_avm_read(readA), .o_avm_address(addrA),
        .i_avm_readdata(readdataA), .o_sensor_state(stateA), .o_changed(changedA),
        .i_irq_ack(ackA), .o_irq(irqA), .o_overrun(overrunA), .o_busy(busyA)
    );

    sensor_poll_scheduler #(.N_SENSORS(4), .POLL_DIV(8)) dutB (
        .i_clk(clk), .i_reset(resetB), .i_enable(enableB),
        .o_avm_sel(selB), .o_avm_read(readB), .o_avm_address(addrB),
        .i_avm_readdata(32'h0), .o_sensor_state(stateB), .o_changed(changedB),
        .i_irq_ack(4'b0), .o_irq(irqB), .o_overrun(overrunB), .o_busy(busyB)
    );

    // PIO slaves answer with latency 1; upper data bits carry junk the DUT must ignore.
    always @(posedge clk) prevSelA <= readA ? selA : 4'b0;
    assign readdataA = 32'hDEAD_BEE0 | {31'b0, |(prevSelA & slaveValsA)};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] slaves, input logic [3:0] ack);
        slaveValsA = slaves;
        ackA       = ack;
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_sel"},     32'(selA),     32'h0);
        checkOutput({tag, "_read"},    32'(readA),    32'h0);
        checkOutput({tag, "_addr"},    32'(addrA),    32'h0);
        checkOutput({tag, "_state"},   32'(stateA),   32'h0);
        checkOutput({tag, "_changed"}, 32'(changedA), 32'h0);
        checkOutput({tag, "_irq"},     32'(irqA),     32'h0);
        checkOutput({tag, "_overrun"}, 32'(overrunA), 32'h0);
        checkOutput({tag, "_busy"},    32'(busyA),    32'h0);
    endtask

    task automatic waitSweepStart(input bit useB, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(useB ? busyB : busyA) && n < 60);
        checkOutput(useB ? "sweepStartB" : "sweepStartA", 32'(useB ? busyB : busyA), 32'h1);
    endtask

    // Entered on the ISSUE cycle of sensor 0; leaves one cycle after the sweep ends.
    task automatic runSweepA(input logic [3:0] expState, input logic [3:0] expChanged,
                             input logic [3:0] ackMask, input int ackIdx);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("issue%0d_read", k), 32'(readA), 32'h1);
            checkOutput($sformatf("issue%0d_sel", k), 32'(selA), 32'(4'b1 << k));
            checkOutput($sformatf("issue%0d_busy", k), 32'(busyA), 32'h1);
            @(negedge clk);
            checkOutput($sformatf("capture%0d_readsel", k), 32'({readA, selA}), 32'h0);
            if (k == ackIdx) ackA = ackMask;
            @(negedge clk);
            ackA = 4'b0;
        end
        checkOutput("sweepEnd_busy", 32'(busyA), 32'h0);
        checkOutput("sweepEnd_state", 32'(stateA), 32'(expState));
        checkOutput("sweepEnd_changed", 32'(changedA), 32'(expChanged));
        @(negedge clk);
        checkOutput("sweepEnd_irq", 32'(irqA), 32'(|expChanged));
    endtask

    task automatic clearChangedA(input logic [3:0] mask);
        ackA = mask;
        @(negedge clk);
        ackA = 4'b0;
        checkOutput("ack_changed", 32'(changedA), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        bit  seenBusy;

        resetA = 1'b1; enableA = 1'b0;
        resetB = 1'b1; enableB = 1'b0;
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        checkResetA("reset");
        checkOutput("resetB_overrun", 32'(overrunB), 32'h0);

        $display("[TB] quiet sweeps, all slaves 0");
        resetA = 1'b0; enableA = 1'b1;
        waitSweepStart(1'b0, n);
        runSweepA(4'b0000, 4'b0000, 4'b0000, -1);
        waitSweepStart(1'b0, n);
        checkOutput("tick_period", 32'(n), 32'd11);
        runSweepA(4'b0000, 4'b0000, 4'b0000, -1);

        $display("[TB] slave 2 rises, then acknowledge");
        applyStimulus(4'b0100, 4'b0000);
        waitSweepStart(1'b0, n);
        runSweepA(4'b0100, 4'b0100, 4'b0000, -1);
        ackA = 4'b0100;
        @(negedge clk);
        ackA = 4'b0000;
        checkOutput("ack2_changed", 32'(changedA), 32'h0);
        checkOutput("ack2_irqLag", 32'(irqA), 32'h1);
        @(negedge clk);
        checkOutput("ack2_irq", 32'(irqA), 32'h0);

        $display("[TB] slave 1 rises with same-cycle acknowledge");
        applyStimulus(4'b0110, 4'b0000);
        waitSweepStart(1'b0, n);
        runSweepA(4'b0110, 4'b0010, 4'b0010, 1);
        clearChangedA(4'b0010);

        $display("[TB] slave 2 falls");
        applyStimulus(4'b0010, 4'b0000);
        waitSweepStart(1'b0, n);
        runSweepA(4'b0010, 4'b0100, 4'b0000, -1);
        clearChangedA(4'b0100);

        $display("[TB] reset during CAPTURE of sensor 1");
        applyStimulus(4'b0011, 4'b0000);
        waitSweepStart(1'b0, n);
        repeat (3) @(negedge clk);
        checkOutput("midReset_inCapture1", 32'({busyA, readA}), 32'h2);
        resetA = 1'b1; enableA = 1'b0;
        @(negedge clk);
        checkResetA("midReset");
        resetA = 1'b0;
        seenBusy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busyA) seenBusy = 1'b1;
        end
        checkOutput("disabled_noSweep", 32'(seenBusy), 32'h0);

        $display("[TB] first sweep after reset accepts single samples");
        enableA = 1'b1;
        waitSweepStart(1'b0, n);
        runSweepA(4'b0011, 4'b0011, 4'b0000, -1);
        clearChangedA(4'b0011);

        $display("[TB] enable drops mid-sweep");
        waitSweepStart(1'b0, n);
        enableA = 1'b0;
        runSweepA(4'b0011, 4'b0000, 4'b0000, -1);
        seenBusy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busyA) seenBusy = 1'b1;
        end
        checkOutput("enableOff_staysIdle", 32'(seenBusy), 32'h0);

        $display("[TB] overrun with an 8-cycle poll period");
        resetB = 1'b0; enableB = 1'b1;
        waitSweepStart(1'b1, n);
        repeat (7) @(negedge clk);
        checkOutput("overrun_beforeTick", 32'(overrunB), 32'h0);
        @(negedge clk);
        checkOutput("overrun_set", 32'(overrunB), 32'h1);
        checkOutput("overrun_idle", 32'(busyB), 32'h0);
        seenBusy = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (busyB) seenBusy = 1'b1;
        end
        checkOutput("overrun_tickDropped", 32'(seenBusy), 32'h0);
        @(negedge clk);
        checkOutput("overrun_nextSweep", 32'(busyB), 32'h1);
        checkOutput("overrun_sticky", 32'(overrunB), 32'h1);
        resetB = 1'b1;
        @(negedge clk);
        checkOutput("overrun_resetClears", 32'(overrunB), 32'h0);
        checkOutput("overrun_resetBusy", 32'(busyB), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
